// File: rtl/gnrl_arb_pkg.sv
// gnrl_arb_pkg: shared state encoding and rotate-priority helper for the round-robin stage
package gnrl_arb_pkg;
    localparam logic ARB_ST  = 1'b0;
    localparam logic LOCK_ST = 1'b1;
    function automatic int rot_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction
endpackage

// File: rtl/gnrl_rr_pick.sv
// gnrl_rr_pick: combinational rotate-priority picker starting the search at ptr
module gnrl_rr_pick
    import gnrl_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);
    int idx;
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        // walk from the furthest offset back so the nearest requester after ptr wins
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = rot_idx(int'(ptr), i, NREQ);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/gnrl_rr_arb_stage.sv
// gnrl_rr_arb_stage: round-robin arbiter with grant lock feeding one registered valid/ready stage
module gnrl_rr_arb_stage
    import gnrl_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    i_vld,
    output logic [NREQ-1:0]    i_rdy,
    input  logic [NREQ*DW-1:0] i_dat,
    input  logic [NREQ-1:0]    i_lock,
    output logic               o_vld,
    input  logic               o_rdy,
    output logic [DW-1:0]      o_dat,
    output logic [IDW-1:0]     o_id
);
    logic            state;
    logic [IDW-1:0]  ptr, lk, pick_id, acc_id;
    logic [NREQ-1:0] pick_gnt, sel;
    logic            pick_any, can_acc, acc;
    gnrl_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req   (i_vld),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .gnt_id(pick_id),
        .any   (pick_any)
    );
    assign can_acc = ~o_vld | o_rdy;
    // a locked owner keeps ready even while it is idle, starving everyone else
    always_comb begin
        sel    = (state == LOCK_ST) ? NREQ'(1) << lk : pick_gnt;
        i_rdy  = (can_acc & ~rst) ? sel : '0;
        acc_id = (state == LOCK_ST) ? lk : pick_id;
        acc    = ~rst & can_acc & ((state == LOCK_ST) ? i_vld[acc_id] : pick_any);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            o_vld <= 1'b0;
            o_dat <= '0;
            o_id  <= '0;
            ptr   <= '0;
            lk    <= '0;
            state <= ARB_ST;
        end else if (acc) begin
            o_vld <= 1'b1;
            o_dat <= i_dat[int'(acc_id)*DW +: DW];
            o_id  <= acc_id;
            if (i_lock[acc_id]) begin
                state <= LOCK_ST;
                lk    <= acc_id;
            end else begin
                state <= ARB_ST;
                ptr   <= (acc_id == IDW'(NREQ - 1)) ? '0 : acc_id + IDW'(1);
            end
        end else if (o_rdy) begin
            o_vld <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gnrl_rr_arb_stage.sv
// tb_gnrl_rr_arb_stage: directed scenarios plus random traffic against a transaction-level model
module tb_gnrl_rr_arb_stage;
    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int IDW  = 2;
    logic               clk = 1'b0;
    logic               rst, o_rdy, o_vld;
    logic [NREQ-1:0]    i_vld, i_rdy, i_lock;
    logic [NREQ*DW-1:0] i_dat;
    logic [DW-1:0]      o_dat;
    logic [IDW-1:0]     o_id;
    logic [DW-1:0]      dat [NREQ];
    int n_chk = 0, n_fail = 0;
    int m_ptr = 0, m_lk = 0, m_id = 0, m_acc = -1;
    bit m_lock = 0;
    logic m_vld = 1'b0;
    logic [DW-1:0] m_dat = '0;
    always #5 clk = ~clk;
    always_comb begin
        i_dat = '0;
        for (int k = 0; k < NREQ; k++) i_dat[k*DW +: DW] = dat[k];
    end
    gnrl_rr_arb_stage #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .i_vld(i_vld), .i_rdy(i_rdy), .i_dat(i_dat), .i_lock(i_lock),
        .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat), .o_id(o_id)
    );
    function automatic logic [NREQ-1:0] model_rdy();
        logic [NREQ-1:0] r = '0;
        if (rst || (m_vld && !o_rdy)) return '0;
        if (m_lock) begin
            r[m_lk] = 1'b1;
            return r;
        end
        for (int j = 0; j < NREQ; j++)
            if (i_vld[(m_ptr + j) % NREQ]) begin
                r[(m_ptr + j) % NREQ] = 1'b1;
                return r;
            end
        return r;
    endfunction
    task automatic tick();
        logic [NREQ-1:0] r;
        r = model_rdy();
        @(posedge clk);
        m_acc = -1;
        if (rst) begin
            m_ptr = 0; m_lock = 0; m_lk = 0; m_vld = 1'b0; m_dat = '0; m_id = 0;
        end else begin
            for (int k = 0; k < NREQ; k++) if (i_vld[k] && r[k]) m_acc = k;
            if (m_acc >= 0) begin
                m_vld = 1'b1; m_dat = dat[m_acc]; m_id = m_acc;
                if (i_lock[m_acc]) begin
                    m_lock = 1; m_lk = m_acc;
                end else begin
                    m_lock = 0; m_ptr = (m_acc + 1) % NREQ;
                end
            end else if (o_rdy) m_vld = 1'b0;
        end
        @(negedge clk);
    endtask
    task automatic test_reset();
        rst = 1'b1; i_vld = '1; i_lock = '0; o_rdy = 1'b1;
        for (int k = 0; k < NREQ; k++) dat[k] = $urandom;
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            #1; n_chk++;
            if (i_rdy !== '0) begin n_fail++; $display("FAIL reset_rdy got %b want 0000", i_rdy); end
            tick();
            n_chk++;
            if ({o_vld, o_id, o_dat} !== '0) begin
                n_fail++; $display("FAIL reset_out got vld=%b id=%0d dat=%h want 0/0/0", o_vld, o_id, o_dat);
            end
        end
        rst = 1'b0;
    endtask
    task automatic test_round_robin();
        for (int k = 0; k < NREQ; k++) dat[k] = DW'(32'hA0 + k);
        i_vld = '1; i_lock = '0; o_rdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1; n_chk++;
            if (i_rdy !== model_rdy() || i_rdy !== (NREQ'(1) << (c % NREQ))) begin
                n_fail++; $display("FAIL rr_rdy c=%0d got %b want %b", c, i_rdy, NREQ'(1) << (c % NREQ));
            end
            tick();
            n_chk++;
            if (o_vld !== 1'b1 || o_id !== IDW'(c % NREQ) || o_dat !== DW'(32'hA0 + c % NREQ)) begin
                n_fail++; $display("FAIL rr_out c=%0d got vld=%b id=%0d dat=%h want 1/%0d/%h",
                                   c, o_vld, o_id, o_dat, c % NREQ, 32'hA0 + c % NREQ);
            end
        end
    endtask
    task automatic test_sparse();
        int want;
        i_vld = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            want = (c % 2 == 1) ? 3 : 1;
            #1; n_chk++;
            if (i_rdy !== (NREQ'(1) << want) || (i_rdy & 4'b0101) !== '0) begin
                n_fail++; $display("FAIL sparse_rdy c=%0d got %b want %b", c, i_rdy, NREQ'(1) << want);
            end
            tick();
            n_chk++;
            if (o_vld !== 1'b1 || o_id !== IDW'(want) || o_dat !== m_dat) begin
                n_fail++; $display("FAIL sparse_out c=%0d got id=%0d dat=%h want %0d/%h", c, o_id, o_dat, want, m_dat);
            end
            dat[want] = $urandom;
        end
    endtask
    task automatic test_backpressure();
        logic [DW-1:0] hold;
        i_vld = 4'b0100; hold = dat[2];
        tick();
        n_chk++;
        if (o_vld !== 1'b1 || o_id !== 2'd2) begin n_fail++; $display("FAIL bp_load got vld=%b id=%0d want 1/2", o_vld, o_id); end
        dat[2] = $urandom; i_vld = '1; o_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1; n_chk++;
            if (i_rdy !== '0) begin n_fail++; $display("FAIL bp_rdy c=%0d got %b want 0000", c, i_rdy); end
            tick();
            n_chk++;
            if (o_vld !== 1'b1 || o_id !== 2'd2 || o_dat !== hold) begin
                n_fail++; $display("FAIL bp_hold c=%0d got vld=%b id=%0d dat=%h want 1/2/%h", c, o_vld, o_id, o_dat, hold);
            end
        end
        o_rdy = 1'b1;
        #1; n_chk++;
        if (i_rdy !== 4'b1000) begin n_fail++; $display("FAIL bp_release_rdy got %b want 1000", i_rdy); end
        tick();
        n_chk++;
        if (o_vld !== 1'b1 || o_id !== 2'd3 || o_dat !== dat[3]) begin
            n_fail++; $display("FAIL bp_release_out got vld=%b id=%0d dat=%h want 1/3/%h", o_vld, o_id, o_dat, dat[3]);
        end
    endtask
    task automatic test_lock();
        i_vld = 4'b0001; i_lock = '0;
        tick();
        i_vld = '1;
        for (int c = 0; c < 3; c++) begin
            i_lock = (c < 2) ? 4'b1111 : 4'b1101;
            #1; n_chk++;
            if (i_rdy !== 4'b0010) begin n_fail++; $display("FAIL lock_rdy c=%0d got %b want 0010", c, i_rdy); end
            tick();
            n_chk++;
            if (o_vld !== 1'b1 || o_id !== 2'd1 || o_dat !== m_dat) begin
                n_fail++; $display("FAIL lock_out c=%0d got id=%0d dat=%h want 1/%h", c, o_id, o_dat, m_dat);
            end
            dat[1] = $urandom;
        end
        i_lock = '0;
        #1; n_chk++;
        if (i_rdy !== 4'b0100) begin n_fail++; $display("FAIL lock_after_rdy got %b want 0100", i_rdy); end
        tick();
        n_chk++;
        if (o_id !== 2'd2) begin n_fail++; $display("FAIL lock_after_id got %0d want 2", o_id); end
    endtask
    task automatic test_lock_stall();
        i_vld = 4'b1000; i_lock = '0;
        tick();
        i_vld = '1; i_lock = 4'b0001;
        #1; n_chk++;
        if (i_rdy !== 4'b0001) begin n_fail++; $display("FAIL stall_grab_rdy got %b want 0001", i_rdy); end
        tick();
        i_vld = 4'b1110; i_lock = '0;
        for (int c = 0; c < 4; c++) begin
            #1; n_chk++;
            if ((i_rdy & 4'b1110) !== '0 || i_rdy !== model_rdy()) begin
                n_fail++; $display("FAIL stall_rdy c=%0d got %b want %b", c, i_rdy, model_rdy());
            end
            tick();
            n_chk++;
            if (o_vld !== 1'b0) begin n_fail++; $display("FAIL stall_drain c=%0d got vld=%b want 0", c, o_vld); end
        end
        i_vld = '1; dat[0] = $urandom;
        #1; n_chk++;
        if (i_rdy !== 4'b0001) begin n_fail++; $display("FAIL stall_return_rdy got %b want 0001", i_rdy); end
        tick();
        n_chk++;
        if (o_vld !== 1'b1 || o_id !== 2'd0 || o_dat !== dat[0]) begin
            n_fail++; $display("FAIL stall_return_out got vld=%b id=%0d dat=%h want 1/0/%h", o_vld, o_id, o_dat, dat[0]);
        end
    endtask
    task automatic test_reset_mid();
        i_vld = 4'b0100; i_lock = '0;
        tick();
        i_vld = 4'b1000; i_lock = 4'b1000;
        tick();
        o_rdy = 1'b0; i_vld = '1; i_lock = '0;
        tick();
        n_chk++;
        if (o_vld !== 1'b1 || o_id !== 2'd3) begin n_fail++; $display("FAIL rmid_hold got vld=%b id=%0d want 1/3", o_vld, o_id); end
        rst = 1'b1;
        #1; n_chk++;
        if (i_rdy !== '0) begin n_fail++; $display("FAIL rmid_rdy got %b want 0000", i_rdy); end
        tick();
        n_chk++;
        if (o_vld !== 1'b0 || o_id !== 2'd0 || o_dat !== '0) begin
            n_fail++; $display("FAIL rmid_clear got vld=%b id=%0d dat=%h want 0/0/0", o_vld, o_id, o_dat);
        end
        rst = 1'b0; o_rdy = 1'b1; i_vld = 4'b1001;
        #1; n_chk++;
        if (i_rdy !== 4'b0001) begin n_fail++; $display("FAIL rmid_first_rdy got %b want 0001", i_rdy); end
        tick();
        n_chk++;
        if (o_vld !== 1'b1 || o_id !== 2'd0) begin n_fail++; $display("FAIL rmid_first_out got vld=%b id=%0d want 1/0", o_vld, o_id); end
    endtask
    task automatic test_random();
        i_vld = '0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NREQ; k++)
                if (!i_vld[k] && $urandom_range(0, 1) == 1) begin
                    i_vld[k] = 1'b1; dat[k] = $urandom;
                end
            i_lock = NREQ'($urandom);
            o_rdy = ($urandom_range(0, 3) != 0);
            #1; n_chk++;
            if (i_rdy !== model_rdy()) begin n_fail++; $display("FAIL rand_rdy c=%0d got %b want %b", c, i_rdy, model_rdy()); end
            tick();
            n_chk++;
            if (o_vld !== m_vld || o_id !== IDW'(m_id) || o_dat !== m_dat) begin
                n_fail++; $display("FAIL rand_out c=%0d got %b/%0d/%h want %b/%0d/%h", c, o_vld, o_id, o_dat, m_vld, m_id, m_dat);
            end
            if (m_acc >= 0) i_vld[m_acc] = 1'b0;
        end
    endtask
    initial begin
        test_reset();
        test_round_robin();
        test_sparse();
        test_backpressure();
        test_lock();
        test_lock_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
